// File: rtl/tetris_ram_pkg.sv
// Shared types and default widths for the Tetris board/data RAM arbiter.
package tetris_ram_pkg;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } clr_state_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_CPU,
      SRC_VID,
      SRC_CLR
   } src_t;

endpackage

// File: rtl/ram_clear_engine.sv
// Zero-fill engine: walks a wrapping address window, one word per granted slot.
module ram_clear_engine
   import tetris_ram_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] start_base,
   input  logic [AW-1:0] start_len,
   output logic          slot_req,
   input  logic          slot_ack,
   output logic [AW-1:0] slot_addr,
   output logic          busy,
   output logic          done
);

   localparam logic [AW-1:0] ONE = AW'(1);

   clr_state_t    state, state_next;
   logic [AW-1:0] base, len, cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         base  <= '0;
         len   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            base <= start_base;
            len  <= start_len;
            cnt  <= '0;
         end else if (state == RUN && slot_ack) begin
            cnt <= cnt + ONE;
         end
      end
   end

   // A start pulse only counts in IDLE, so a pulse during DONE is dropped.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (start_len == '0) ? DONE : RUN;
         RUN:     if (slot_ack && cnt == len - ONE) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign slot_req  = (state == RUN);
   assign slot_addr = base + cnt;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

endmodule

// File: rtl/tetris_ram_arbiter.sv
// Single-port RAM arbiter for CPU, display scanner and clear engine, with
// display starvation guard and registered read return.
module tetris_ram_arbiter
   import tetris_ram_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_gnt,
   output logic          vid_rvalid,
   output logic [DW-1:0] vid_rdata,
   input  logic          clr_start,
   input  logic [AW-1:0] clr_base,
   input  logic [AW-1:0] clr_len,
   output logic          clr_busy,
   output logic          clr_done,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_d,
   output logic          ram_we,
   input  logic [DW-1:0] ram_q
);

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   src_t          sel;
   logic [3:0]    wait_cnt;
   logic          clr_slot_req;
   logic [AW-1:0] clr_slot_addr;

   ram_clear_engine #(.AW(AW)) u_clear (
      .clk        (clk),
      .rst        (rst),
      .start      (clr_start),
      .start_base (clr_base),
      .start_len  (clr_len),
      .slot_req   (clr_slot_req),
      .slot_ack   (sel == SRC_CLR),
      .slot_addr  (clr_slot_addr),
      .busy       (clr_busy),
      .done       (clr_done)
   );

   // A display that has waited MAX_WAIT cycles jumps ahead of the CPU.
   always_comb begin
      sel = SRC_NONE;
      if (!rst) begin
         if (vid_req && wait_cnt == WAIT_LIMIT) sel = SRC_VID;
         else if (cpu_req)                      sel = SRC_CPU;
         else if (vid_req)                      sel = SRC_VID;
         else if (clr_slot_req)                 sel = SRC_CLR;
      end
   end

   assign cpu_gnt = (sel == SRC_CPU);
   assign vid_gnt = (sel == SRC_VID);

   always_comb begin
      ram_addr = '0;
      ram_d    = '0;
      ram_we   = 1'b0;
      case (sel)
         SRC_CPU: begin
            ram_addr = cpu_addr;
            ram_d    = cpu_wdata;
            ram_we   = cpu_we;
         end
         SRC_VID: ram_addr = vid_addr;
         SRC_CLR: begin
            ram_addr = clr_slot_addr;
            ram_we   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (!vid_req || vid_gnt) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LIMIT) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         vid_rvalid <= 1'b0;
         vid_rdata  <= '0;
      end else begin
         cpu_rvalid <= cpu_gnt && !cpu_we;
         vid_rvalid <= vid_gnt;
         if (cpu_gnt && !cpu_we) cpu_rdata <= ram_q;
         if (vid_gnt)            vid_rdata <= ram_q;
      end
   end

endmodule

// File: doc/tetris_ram_arbiter.md
# tetris_ram_arbiter

Single-owner access controller for the 1024×16 board/data RAM of the Tetris CPU: shares the RAM's one address/data/write-enable port between the CPU, the display scanner and a built-in clear engine. The block sits between those requesters and the RAM. It applies fixed priority with a starvation guard for the display, and returns registered read data. The clear engine zero-fills a programmable address window, used on game start and line collapse.

## Interface
Parameters:
- AW, 10, RAM address width
- DW, 16, RAM data width
- MAX_WAIT, 4, cycles the display may be refused before it is promoted above the CPU (1..15)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request; cpu_we/addr/wdata held stable while req=1 and gnt=0
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  combinational; access performed at this edge
- cpu_rvalid  out  1  registered; read data valid, one cycle after a read grant
- cpu_rdata  out  DW  registered read data
- vid_req  in  1  display read request (read-only requester)
- vid_addr  in  AW  display word address
- vid_gnt  out  1  combinational grant
- vid_rvalid  out  1  registered read-valid
- vid_rdata  out  DW  registered read data
- clr_start  in  1  one-cycle pulse starting a clear; ignored while clr_busy
- clr_base  in  AW  first address to clear, sampled on accepted clr_start
- clr_len  in  AW  number of words to clear, sampled on accepted clr_start
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after last word written
- ram_addr  out  AW  to RAM addr
- ram_d  out  DW  to RAM d
- ram_we  out  1  to RAM we
- ram_q  in  DW  from RAM q (combinational read)

## Operation
- One RAM access per cycle. Exactly one of cpu_gnt, vid_gnt or clear-slot is active, or none.
- Priority, evaluated every cycle:
  - display first, if vid_req and wait_cnt==MAX_WAIT;
  - else CPU;
  - else display;
  - else clear engine (RUN state).
- wait_cnt: increments when vid_req=1 and vid_gnt=0, saturating at MAX_WAIT. Clears to 0 on vid_gnt or vid_req=0.
- Mux: ram_addr/ram_d/ram_we come from the granted source. When idle, ram_addr=0, ram_d=0, ram_we=0. The display and clear reads never drive ram_we. A clear write drives ram_d=0 and ram_we=1.
- Read return: on a read grant, ram_q is captured into the requester's rdata and its rvalid=1 at the next edge. rdata holds its value until the next read of that requester.
- Clear FSM:
  - IDLE: on clr_start, latch base/len and set cnt=0. If len==0, go to DONE; else go to RUN.
  - RUN: each clear slot writes address (base+cnt) mod 2^AW and increments cnt. After the write with cnt==len-1, go to DONE.
  - DONE: clr_done=1 for one cycle, then IDLE.
  - clr_busy=1 in RUN and DONE.
- Address arithmetic is AW bits wide and wraps; base=1020, len=8 clears 1020..1023 then 0..3.
- Simultaneous events:
  - a CPU write to an address being cleared lands in grant order; a CPU write after the clear slot wins;
  - clr_start in the same cycle as clr_done is ignored.

## Timing
- Grant: same cycle as request (combinational from req, wait_cnt, FSM state). A request is completed at the rising edge where gnt=1.
- Read latency: 1 cycle, with rvalid asserted the cycle after gnt.
- A back-to-back CPU stream delays the display at most MAX_WAIT cycles. With continuous CPU and display requests, the display gets 1 of every MAX_WAIT+1 slots.
- Clear of N words with no other traffic: clr_busy rises 1 cycle after clr_start, clr_done pulses N+1 cycles after clr_start (len=0: done 1 cycle after start).
- Reset values: all gnt/rvalid 0, rdata 0, clr_busy 0, clr_done 0, wait_cnt 0, FSM IDLE, ram_we 0.
- While rst=1, all grants are forced 0.
- Reset mid-clear aborts with no clr_done; the partial clear remains.

## Structure
- Package tetris_ram_pkg:
  - AW/DW constants;
  - clear FSM state enum (IDLE, RUN, DONE);
  - source-select enum (SRC_NONE, SRC_CPU, SRC_VID, SRC_CLR).
- Sub-module ram_clear_engine: FSM, base/len/cnt registers, and slot request/ack.
- Top level holds the arbiter, wait counter, mux and read-return registers.

## Test plan
- CPU write 0x1234 to addr 5, then read addr 5: cpu_gnt in the request cycle; cpu_rvalid=1 and cpu_rdata=0x1234 the cycle after the read grant.
- CPU and display both requesting every cycle, MAX_WAIT=4: vid_gnt exactly every 5th cycle, never more than 4 consecutive refusals.
- Clear base=1020 len=8 with idle requesters: 8 consecutive ram_we with addresses 1020..1023,0..3 and ram_d=0. clr_done 9 cycles after start; RAM reads 0 at those addresses.
- Clear of 4 words while the CPU requests continuously: no clear writes until the CPU drops req; clr_done follows 4 free slots later.
- clr_len=0: no ram_we, clr_done pulses 1 cycle after clr_start. A second clr_start while busy is ignored.
- Assert rst in the middle of RUN: next cycle clr_busy=0, no clr_done, grants 0, rdata 0.
